pipeline_hazard_ctrl: RTL

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard control for a five-stage pipeline with an extra EXT writeback stage.
// Handles memory freeze, branch flush, multi-cycle EX ops, load-use and forwarding.
module pipeline_hazard_ctrl #(
    parameter int MC_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rs1_ID,
    input  logic [4:0] rs2_ID,
    input  logic [1:0] use_ID,
    input  logic [4:0] rd_EX,
    input  logic [4:0] rd_MA,
    input  logic [4:0] rd_WB,
    input  logic [4:0] rd_EXT,
    input  logic       regwrite_EX,
    input  logic       regwrite_MA,
    input  logic       regwrite_WB,
    input  logic       regwrite_EXT,
    input  logic       isLd_EX,
    input  logic       mc_start_EX,
    input  logic       branch_taken_EX,
    input  logic       mem_wait_MA,
    output logic       stall_IFID,
    output logic       stall_IDEX,
    output logic       stall_EXMA,
    output logic       stall_MAWB,
    output logic       stall_WBEXT,
    output logic       flush_IFID,
    output logic       flush_IDEX,
    output logic       flush_EXMA,
    output logic [1:0] fwdA_sel,
    output logic [1:0] fwdB_sel,
    output logic       state,
    output logic       mc_done
);

    typedef enum logic {
        RUN    = 1'b0,
        MCBUSY = 1'b1
    } state_t;

    // The start cycle counts as one EX cycle and the cnt==0 cycle as the last.
    localparam logic [3:0] CNT_INIT = 4'(MC_CYCLES - 2);

    state_t     cur_state;
    state_t     nxt_state;
    logic [3:0] cnt;
    logic [3:0] cnt_nxt;
    logic       load_use;

    assign state = cur_state;

    // Forward source for one operand: youngest producing stage wins.
    function automatic logic [1:0] fwd_pick(
        input logic [4:0] rs,
        input logic [4:0] rma,
        input logic       wma,
        input logic [4:0] rwb,
        input logic       wwb,
        input logic [4:0] rext,
        input logic       wext
    );
        logic [1:0] sel;
        sel = 2'd0;
        if (wma && (rma == rs)) begin
            sel = 2'd1;
        end else if (wwb && (rwb == rs)) begin
            sel = 2'd2;
        end else if (wext && (rext == rs)) begin
            sel = 2'd3;
        end
        return sel;
    endfunction

    // State and multi-cycle counter register; reset abandons any op in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state <= RUN;
            cnt       <= 4'd0;
        end else begin
            cur_state <= nxt_state;
            cnt       <= cnt_nxt;
        end
    end

    // Load in EX producing a register that ID is about to read.
    always_comb begin
        load_use = 1'b0;
        if (isLd_EX && regwrite_EX) begin
            if (use_ID[0] && (rd_EX == rs1_ID)) begin
                load_use = 1'b1;
            end
            if (use_ID[1] && (rd_EX == rs2_ID)) begin
                load_use = 1'b1;
            end
        end
    end

    // Next state and stall/flush controls; memory freeze overrides everything.
    always_comb begin
        nxt_state   = cur_state;
        cnt_nxt     = cnt;
        stall_IFID  = 1'b0;
        stall_IDEX  = 1'b0;
        stall_EXMA  = 1'b0;
        stall_MAWB  = 1'b0;
        stall_WBEXT = 1'b0;
        flush_IFID  = 1'b0;
        flush_IDEX  = 1'b0;
        flush_EXMA  = 1'b0;
        mc_done     = 1'b0;
        if (mem_wait_MA) begin
            stall_IFID  = 1'b1;
            stall_IDEX  = 1'b1;
            stall_EXMA  = 1'b1;
            stall_MAWB  = 1'b1;
            stall_WBEXT = 1'b1;
        end else begin
            case (cur_state)
                RUN: begin
                    if (branch_taken_EX) begin
                        flush_IFID = 1'b1;
                        flush_IDEX = 1'b1;
                    end else if (mc_start_EX) begin
                        stall_IFID = 1'b1;
                        stall_IDEX = 1'b1;
                        flush_EXMA = 1'b1;
                        cnt_nxt    = CNT_INIT;
                        nxt_state  = MCBUSY;
                    end else if (load_use) begin
                        stall_IFID = 1'b1;
                        flush_IDEX = 1'b1;
                    end
                end
                MCBUSY: begin
                    if (cnt != 4'd0) begin
                        stall_IFID = 1'b1;
                        stall_IDEX = 1'b1;
                        flush_EXMA = 1'b1;
                        cnt_nxt    = cnt - 4'd1;
                    end else begin
                        mc_done   = 1'b1;
                        nxt_state = RUN;
                    end
                end
                default: begin
                    nxt_state = RUN;
                    cnt_nxt   = 4'd0;
                end
            endcase
        end
    end

    // Operand forwarding is independent of state and of the use bits.
    always_comb begin
        fwdA_sel = fwd_pick(rs1_ID, rd_MA, regwrite_MA, rd_WB, regwrite_WB,
                            rd_EXT, regwrite_EXT);
        fwdB_sel = fwd_pick(rs2_ID, rd_MA, regwrite_MA, rd_WB, regwrite_WB,
                            rd_EXT, regwrite_EXT);
    end

endmodule
